debug_ocimem_cmd: RTL and testbench

DEBUG_OCIMEM_CMD -- requirements
Module: debug_ocimem_cmd

---
 rtl/debug_ocimem_cmd.sv | 199 +++++++++++++++++++
 tb/tb_debug_ocimem_cmd.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_ocimem_cmd.sv
// JTAG-to-debug-RAM command engine with CPU-priority arbitration.
// One 32-bit RAM port is shared between the JTAG FSM and a CPU slave port.
module debug_ocimem_cmd #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest
);

  localparam int SW = $clog2(STARVE_MAX + 2);

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]       r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_jaddr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic [SW-1:0]     r_starve;
  logic [31:0]       r_mon;
  logic              r_ready;
  logic              r_error;

  logic w_idle;
  logic w_in_req;
  logic w_cpu_req;
  logic w_forced;
  logic w_grant;
  logic w_cpu_go;
  logic w_cpu_wr;
  logic w_cpu_rd;
  logic w_any_pulse;
  logic w_acc_a;
  logic w_acc_b;
  logic w_acc_n;
  logic w_drop;
  logic w_rd_cmd;
  logic w_wr_cmd;
  logic w_j_wr;
  logic w_j_rd;

  logic              w_mem_we;
  logic              w_mem_re;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [31:0]       w_mem_wdata;
  logic              w_unused;

  assign w_unused = ^{jdo[37:35], jdo[2:0]};

  assign w_idle    = (r_state == IDLE);
  assign w_in_req  = (r_state == RD_REQ) || (r_state == WR_REQ);
  assign w_cpu_req = avs_read | avs_write;
  assign w_forced  = w_in_req && (r_starve == SW'(STARVE_MAX));
  assign w_grant   = w_in_req && (!w_cpu_req || w_forced);

  // CPU owns the RAM port in every cycle the JTAG side is not granted
  assign w_cpu_go = w_cpu_req && !w_grant;
  assign w_cpu_wr = w_cpu_go && avs_write;
  assign w_cpu_rd = w_cpu_go && avs_read && !avs_write;
  assign w_j_wr   = w_grant && (r_state == WR_REQ);
  assign w_j_rd   = w_grant && (r_state == RD_REQ);

  assign w_any_pulse = take_action_ocimem_a | take_action_ocimem_b
                     | take_no_action_ocimem_a;

  // ocimem_a beats everything; write beats read-and-increment
  assign w_acc_a = w_idle && take_action_ocimem_a;
  assign w_acc_b = w_idle && !take_action_ocimem_a && take_action_ocimem_b;
  assign w_acc_n = w_idle && !take_action_ocimem_a && !take_action_ocimem_b
                 && take_no_action_ocimem_a;

  assign w_drop = (!w_idle && w_any_pulse)
               || (w_idle && take_action_ocimem_a
                   && (take_action_ocimem_b || take_no_action_ocimem_a))
               || (w_idle && take_action_ocimem_b && take_no_action_ocimem_a);

  assign w_rd_cmd = (w_acc_a && jdo[17]) || w_acc_n;
  assign w_wr_cmd = w_acc_b;

  assign w_mem_we    = !reset && (w_j_wr || w_cpu_wr);
  assign w_mem_re    = w_j_rd || w_cpu_rd;
  assign w_mem_addr  = w_grant ? r_jaddr : avs_address;
  assign w_mem_wdata = w_grant ? r_wdata : avs_writedata;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_rd_cmd) begin
          w_state_nxt = RD_REQ;
        end else if (w_wr_cmd) begin
          w_state_nxt = WR_REQ;
        end
      end
      RD_REQ: begin
        if (w_grant) w_state_nxt = RD_WAIT;
      end
      RD_WAIT: w_state_nxt = IDLE;
      WR_REQ: begin
        if (w_grant) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_cpu_rd;
      if (w_mem_re) r_rdata <= r_mem[w_mem_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_jaddr  <= '0;
      r_wdata  <= '0;
      r_starve <= '0;
    end else begin
      if (w_acc_a) begin
        r_jaddr <= jdo[17+ADDR_W:18];
      end else if (w_grant) begin
        r_jaddr <= r_jaddr + ADDR_W'(1);
      end
      if (w_acc_b) r_wdata <= jdo[34:3];
      if (w_grant) begin
        r_starve <= '0;
      end else if (w_in_req) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon   <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (r_state == RD_WAIT) r_mon <= r_rdata;
      if (w_rd_cmd || w_wr_cmd) begin
        r_ready <= 1'b0;
      end else if ((r_state == RD_WAIT) || w_j_wr) begin
        r_ready <= 1'b1;
      end
      if (w_drop) begin
        r_error <= 1'b1;
      end else if (w_acc_a && jdo[16]) begin
        r_error <= 1'b0;
      end
    end
  end

  assign MonDReg           = r_mon;
  assign monitor_ready     = r_ready;
  assign monitor_error     = r_error;
  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign avs_waitrequest   = w_forced && w_cpu_req;

endmodule

// File: tb/tb_debug_ocimem_cmd.sv
// Randomized bench for debug_ocimem_cmd with a transaction-level model
// plus directed latency, wrap, starvation, drop and reset scenarios.
module tb_debug_ocimem_cmd;
  localparam int AW = 8;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          ta, tbp, tna;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;
  logic [AW-1:0] avs_address;
  logic          avs_read, avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid, avs_waitrequest;

  debug_ocimem_cmd #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta),
    .take_action_ocimem_b(tbp),
    .take_no_action_ocimem_a(tna),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error),
    .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // transaction-level model
  logic [31:0] m_mem [256];
  logic [7:0]  m_jaddr;
  logic [31:0] m_mon, m_rdata, m_wd, m_rdval;
  logic        m_err, m_ready, m_rdv;
  bit          m_busy, m_granted, m_isrd;
  int          m_wait;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_jaddr = 0; m_mon = 0; m_rdata = 0; m_wd = 0; m_rdval = 0;
    m_err = 0; m_ready = 0; m_rdv = 0;
    m_busy = 0; m_granted = 0; m_isrd = 0; m_wait = 0;
  endtask

  function automatic bit exp_wait();
    return m_busy && !m_granted && (m_wait == SM)
        && (avs_read || avs_write);
  endfunction

  task automatic compare();
    chk("mondreg", MonDReg, m_mon);
    chk("ready", 32'(monitor_ready), 32'(m_ready));
    chk("error", 32'(monitor_error), 32'(m_err));
    chk("rdata", avs_readdata, m_rdata);
    chk("rvalid", 32'(avs_readdatavalid), 32'(m_rdv));
    chk("waitreq", 32'(avs_waitrequest), 32'(exp_wait()));
  endtask

  task automatic start_job(input bit rd, input logic [31:0] d);
    m_busy = 1; m_granted = 0; m_isrd = rd; m_wait = 0;
    m_ready = 0; m_wd = d;
  endtask

  task automatic model_step();
    bit cpu, busy_pre, req, jgo, cgo, anyp;
    if (reset) begin
      model_reset();
      return;
    end
    cpu = avs_read || avs_write;
    busy_pre = m_busy;
    req = m_busy && !m_granted;
    jgo = req && (!cpu || m_wait == SM);
    cgo = cpu && !jgo;
    anyp = ta || tbp || tna;
    if (m_busy && m_granted) begin
      m_mon = m_rdval; m_ready = 1; m_busy = 0; m_granted = 0;
    end
    m_rdv = cgo && avs_read && !avs_write;
    if (cgo) begin
      if (avs_write) m_mem[avs_address] = avs_writedata;
      else m_rdata = m_mem[avs_address];
    end
    if (jgo) begin
      m_wait = 0;
      if (m_isrd) begin
        m_rdval = m_mem[m_jaddr]; m_rdata = m_rdval; m_granted = 1;
      end else begin
        m_mem[m_jaddr] = m_wd; m_ready = 1; m_busy = 0;
      end
      m_jaddr = m_jaddr + 8'd1;
    end else if (req) begin
      m_wait++;
    end
    if (busy_pre) begin
      if (anyp) m_err = 1;
    end else if (ta) begin
      m_jaddr = jdo[25:18];
      if (tbp || tna) m_err = 1;
      else if (jdo[16]) m_err = 0;
      if (jdo[17]) start_job(1, 0);
    end else if (tbp) begin
      if (tna) m_err = 1;
      start_job(0, jdo[34:3]);
    end else if (tna) begin
      start_job(1, 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
    ta = 0; tbp = 0; tna = 0;
  endtask

  function automatic logic [37:0] ja(input logic [7:0] a, input bit rd,
                                     input bit clr);
    logic [37:0] j;
    j = '0; j[25:18] = a; j[17] = rd; j[16] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1;
    tick();
    avs_write = 0;
  endtask

  task automatic cpu_rd_chk(input string nm, input logic [7:0] a,
                            input logic [31:0] d);
    avs_address = a; avs_read = 1;
    tick();
    avs_read = 0;
    chk(nm, avs_readdata, d);
    tick();
  endtask

  task automatic jtag_rd_wait();
    tick(); tick(); tick();
  endtask

  initial begin
    logic [63:0] r64;
    int mode;
    reset = 1; jdo = '0; ta = 0; tbp = 0; tna = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 'x;
    repeat (3) tick();
    reset = 0;
    tick();
    for (int i = 0; i < 256; i++) cpu_wr(8'(i), $urandom());

    // write then read back through jaddr load
    jdo = ja(8'h10, 0, 0); ta = 1; tick();
    jdo = jb(32'hDEADBEEF); tbp = 1; tick(); tick();
    chk("wr_ready", 32'(monitor_ready), 32'd1);
    jdo = ja(8'h10, 1, 0); ta = 1; tick();
    chk("rd_ready_t1", 32'(monitor_ready), 32'd0);
    tick();
    chk("rd_ready_t2", 32'(monitor_ready), 32'd0);
    tick();
    chk("rd_ready_t3", 32'(monitor_ready), 32'd1);
    chk("rd_mon_t3", MonDReg, 32'hDEADBEEF);
    chk("model_mon", m_mon, 32'hDEADBEEF);
    jdo = jb(32'hCAFEF00D); tbp = 1; tick(); tick();
    cpu_rd_chk("jaddr_11", 8'h11, 32'hCAFEF00D);

    // address wrap
    cpu_wr(8'h00, 32'h0A0A0A0A);
    jdo = ja(8'hFF, 0, 0); ta = 1; tick();
    jdo = jb(32'h1); tbp = 1; tick(); tick();
    tna = 1; jtag_rd_wait();
    chk("wrap_mon", MonDReg, 32'h0A0A0A0A);
    cpu_rd_chk("wrap_ff", 8'hFF, 32'h1);

    // starvation: jaddr now 0x01
    avs_address = 8'h05; avs_read = 1;
    jdo = jb(32'h55AA55AA); tbp = 1; tick();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("starve_wr%0d", k), 32'(avs_waitrequest),
          32'(k == 4));
      tick();
    end
    chk("starve_done", 32'(monitor_ready), 32'd1);
    avs_read = 0; tick();
    cpu_rd_chk("starve_data", 8'h01, 32'h55AA55AA);

    // busy drop and error clear: jaddr now 0x02
    jdo = jb(32'h77); tbp = 1; tick();
    jdo = jb(32'h88); tbp = 1; tick();
    tick();
    chk("drop_err", 32'(monitor_error), 32'd1);
    cpu_rd_chk("drop_first", 8'h02, 32'h77);
    cpu_rd_chk("drop_second", 8'h03, m_mem[3]);
    jdo = ja(8'h03, 0, 1); ta = 1; tick();
    chk("err_clear", 32'(monitor_error), 32'd0);

    // reset while in RD_REQ
    cpu_wr(8'h40, 32'h40404040);
    jdo = ja(8'h40, 1, 0); ta = 1; tick();
    reset = 1; model_reset(); #1;
    chk("rst_mon", MonDReg, 32'd0);
    chk("rst_ready", 32'(monitor_ready), 32'd0);
    tick();
    reset = 0; tick();
    cpu_rd_chk("rst_old", 8'h40, 32'h40404040);
    jdo = ja(8'h41, 1, 0); ta = 1; jtag_rd_wait();
    chk("rst_idle", 32'(monitor_ready), 32'd1);

    // randomized traffic
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 25 == 0) mode = int'($urandom_range(0, 3));
      r64 = {$urandom(), $urandom()};
      jdo = r64[37:0];
      case ($urandom_range(0, 9))
        0: ta = 1;
        1: tbp = 1;
        2: tna = 1;
        3: begin ta = ($urandom_range(0, 1) == 1); tbp = 1; tna = 1; end
        default: ;
      endcase
      avs_address = 8'($urandom());
      avs_writedata = $urandom();
      avs_read = ($urandom_range(0, 3) < mode);
      avs_write = ($urandom_range(0, 4) < mode);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1; model_reset(); tick(); reset = 0;
      end
      tick();
    end
    avs_read = 0; avs_write = 0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
